// File: rtl/id_pkg.sv
// Shared opcode, EXE command, branch-type encodings and the decoded control bundle
// for the decode stage.
package id_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_SUB = 4'd2;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic [1:0] br_type;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       is_imm;
    logic       one_input;
    logic       is_nop;
  } ctrl_t;

endpackage

// File: rtl/id_stage_pipe_decoder.sv
// Combinational opcode decoder; unknown opcodes decode as NOP with all controls cleared.
module id_decoder
  import id_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl           = '0;
    ctrl.exe_cmd   = EXE_ADD;
    ctrl.br_type   = BR_NONE;
    unique case (opcode)
      OP_ADD:  ctrl.wb_en = 1'b1;
      OP_SUB: begin
        ctrl.exe_cmd = EXE_SUB;
        ctrl.wb_en   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.wb_en     = 1'b1;
        ctrl.is_imm    = 1'b1;
        ctrl.one_input = 1'b1;
      end
      OP_LD: begin
        ctrl.mem_r_en  = 1'b1;
        ctrl.wb_en     = 1'b1;
        ctrl.is_imm    = 1'b1;
        ctrl.one_input = 1'b1;
      end
      OP_ST: begin
        ctrl.mem_w_en = 1'b1;
        ctrl.is_imm   = 1'b1;
      end
      OP_BEZ: begin
        ctrl.br_type   = BR_BEZ;
        ctrl.is_imm    = 1'b1;
        ctrl.one_input = 1'b1;
      end
      OP_BNE: begin
        ctrl.br_type = BR_BNE;
        ctrl.is_imm  = 1'b1;
      end
      OP_JMP: begin
        ctrl.br_type   = BR_JMP;
        ctrl.is_imm    = 1'b1;
        ctrl.one_input = 1'b1;
      end
      default: ctrl.is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with built-in ID/EX register, load-use bubble insertion and bubble counter.
// Optional writeback bypass into operand reads is enabled by defining ID_WB_FWD_EN.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        instr,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_dest,
  input  logic [XLEN-1:0]    wb_data,
  output logic               if_stall,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_src1,
  output logic [RADDR_W-1:0] ex_src2,
  output logic [RADDR_W-1:0] ex_dest,
  output logic [XLEN-1:0]    ex_val1,
  output logic [XLEN-1:0]    ex_val2,
  output logic [XLEN-1:0]    ex_reg2,
  output logic [3:0]         ex_exe_cmd,
  output logic [1:0]         ex_br_type,
  output logic               ex_mem_r_en,
  output logic               ex_mem_w_en,
  output logic               ex_wb_en,
  output logic               ex_one_input,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_t              ctrl;
  logic [4:0]         f_rs, f_rt, f_rd;
  logic [RADDR_W-1:0] src1, src2, dest;
  logic [XLEN-1:0]    op1, op2, imm_ext;
  logic               hz;

  assign f_rs      = instr[25:21];
  assign f_rt      = instr[20:16];
  assign f_rd      = instr[15:11];
  assign rf_raddr1 = RADDR_W'(f_rs);
  assign rf_raddr2 = RADDR_W'(f_rt);

  id_decoder u_dec (
    .opcode (instr[31:26]),
    .ctrl   (ctrl)
  );

`ifdef ID_WB_FWD_EN
  assign op1 = (wb_we && wb_dest != '0 && wb_dest == rf_raddr1) ? wb_data : rf_rdata1;
  assign op2 = (wb_we && wb_dest != '0 && wb_dest == rf_raddr2) ? wb_data : rf_rdata2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_dest, wb_data};
  assign op1 = rf_rdata1;
  assign op2 = rf_rdata2;
`endif

  assign imm_ext = XLEN'($signed(instr[15:0]));
  assign src1    = rf_raddr1;
  assign src2    = ctrl.is_imm ? '0 : rf_raddr2;
  assign dest    = ctrl.is_imm ? rf_raddr2 : RADDR_W'(f_rd);

  // The instruction behind a load must wait one cycle for the loaded value.
  assign hz = in_valid && ex_valid && ex_mem_r_en && (ex_dest != '0) &&
              ((ex_dest == src1) || (!ctrl.one_input && ex_dest == src2));

  assign if_stall = !flush && (stall_in || hz);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_src1      <= '0;
      ex_src2      <= '0;
      ex_dest      <= '0;
      ex_val1      <= '0;
      ex_val2      <= '0;
      ex_reg2      <= '0;
      ex_exe_cmd   <= '0;
      ex_br_type   <= '0;
      ex_mem_r_en  <= 1'b0;
      ex_mem_w_en  <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_one_input <= 1'b0;
      bubble_cnt   <= '0;
    end else if (stall_in && !flush) begin
      // Downstream stall freezes every ID/EX field.
    end else if (flush || hz || !in_valid) begin
      ex_valid     <= 1'b0;
      ex_exe_cmd   <= '0;
      ex_br_type   <= '0;
      ex_mem_r_en  <= 1'b0;
      ex_mem_w_en  <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_one_input <= 1'b0;
      if (!flush && hz && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_valid     <= !ctrl.is_nop;
      ex_src1      <= src1;
      ex_src2      <= src2;
      ex_dest      <= dest;
      ex_val1      <= op1;
      ex_val2      <= ctrl.is_imm ? imm_ext : op2;
      ex_reg2      <= op2;
      ex_exe_cmd   <= ctrl.exe_cmd;
      ex_br_type   <= ctrl.br_type;
      ex_mem_r_en  <= ctrl.mem_r_en;
      ex_mem_w_en  <= ctrl.mem_w_en;
      ex_wb_en     <= ctrl.wb_en;
      ex_one_input <= ctrl.one_input;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; one task per scenario.
module tb_id_stage_pipe;

  localparam int XLEN = 32, RADDR_W = 5, CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [31:0]        instr;
  logic [RADDR_W-1:0] rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]    rf_rdata1, rf_rdata2;
  logic               stall_in, flush;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_dest;
  logic [XLEN-1:0]    wb_data;
  logic               if_stall, ex_valid;
  logic [RADDR_W-1:0] ex_src1, ex_src2, ex_dest;
  logic [XLEN-1:0]    ex_val1, ex_val2, ex_reg2;
  logic [3:0]         ex_exe_cmd;
  logic [1:0]         ex_br_type;
  logic               ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_one_input;
  logic [CNT_W-1:0]   bubble_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI    = 32'h8022FFFC; // ADDI r2,r1,-4
  localparam logic [31:0] I_LD      = 32'h90230000; // LD r3,0(r1)
  localparam logic [31:0] I_ADD_HZ  = 32'h04652000; // ADD r4,r3,r5
  localparam logic [31:0] I_ADD_OK  = 32'h04A02000; // ADD r4,r5,r0
  localparam logic [31:0] I_ADD_HZ2 = 32'h04A32000; // ADD r4,r5,r3
  localparam logic [31:0] I_ST      = 32'h94220008; // ST r2,8(r1)
  localparam logic [31:0] I_BNE     = 32'hA422FFF0; // BNE r1,r2,-16
  localparam logic [31:0] I_UNK     = 32'hFC000000; // opcode 63

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .stall_in(stall_in), .flush(flush),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .if_stall(if_stall), .ex_valid(ex_valid),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_reg2(ex_reg2),
    .ex_exe_cmd(ex_exe_cmd), .ex_br_type(ex_br_type),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_wb_en(ex_wb_en), .ex_one_input(ex_one_input),
    .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; instr = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    stall_in = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_dest = '0; wb_data = '0;
    step();
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("reset_ex_val1", ex_val1, 32'd0);
    chk("reset_if_stall_lo", 32'(if_stall), 32'd0);
    stall_in = 1'b1; #1;
    chk("reset_if_stall_hi", 32'(if_stall), 32'd1);
    stall_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_addi();
    in_valid = 1'b1; instr = I_ADDI; rf_rdata1 = 32'd10; rf_rdata2 = 32'h1234;
    #1;
    chk("addi_raddr1", 32'(rf_raddr1), 32'd1);
    chk("addi_raddr2", 32'(rf_raddr2), 32'd2);
    step();
    chk("addi_ex_valid", 32'(ex_valid), 32'd1);
    chk("addi_ex_val1", ex_val1, 32'd10);
    chk("addi_ex_val2", ex_val2, 32'hFFFFFFFC);
    chk("addi_ex_reg2", ex_reg2, 32'h1234);
    chk("addi_ex_dest", 32'(ex_dest), 32'd2);
    chk("addi_ex_src1", 32'(ex_src1), 32'd1);
    chk("addi_ex_src2", 32'(ex_src2), 32'd0);
    chk("addi_ex_wb_en", 32'(ex_wb_en), 32'd1);
    chk("addi_ex_one_input", 32'(ex_one_input), 32'd1);
    $display("txn addi val1=0x%0h val2=0x%0h dest=%0d", ex_val1, ex_val2, ex_dest);
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; instr = I_LD; rf_rdata1 = 32'h100; rf_rdata2 = 32'd0;
    step();
    chk("ld_ex_mem_r_en", 32'(ex_mem_r_en), 32'd1);
    chk("ld_ex_dest", 32'(ex_dest), 32'd3);
    instr = I_ADD_HZ; rf_rdata1 = 32'd7; rf_rdata2 = 32'd9; #1;
    chk("hz_if_stall", 32'(if_stall), 32'd1);
    step();
    chk("hz_bubble_valid", 32'(ex_valid), 32'd0);
    chk("hz_bubble_wb_en", 32'(ex_wb_en), 32'd0);
    chk("hz_bubble_cnt", 32'(bubble_cnt), 32'd1);
    chk("hz_if_stall_released", 32'(if_stall), 32'd0);
    step();
    chk("hz_reissue_valid", 32'(ex_valid), 32'd1);
    chk("hz_reissue_dest", 32'(ex_dest), 32'd4);
    chk("hz_reissue_src1", 32'(ex_src1), 32'd3);
    chk("hz_reissue_val2", ex_val2, 32'd9);
    $display("txn load-use bubble_cnt=%0d", bubble_cnt);
    // Load followed by an independent ADD: no stall.
    instr = I_LD; step();
    instr = I_ADD_OK; #1;
    chk("nohz_if_stall", 32'(if_stall), 32'd0);
    step();
    chk("nohz_ex_valid", 32'(ex_valid), 32'd1);
    chk("nohz_ex_src2", 32'(ex_src2), 32'd0);
    chk("nohz_bubble_cnt", 32'(bubble_cnt), 32'd1);
    // Load followed by ADD reading the load target as operand 2.
    instr = I_LD; step();
    instr = I_ADD_HZ2; #1;
    chk("hz2_if_stall", 32'(if_stall), 32'd1);
    step();
    chk("hz2_bubble_valid", 32'(ex_valid), 32'd0);
    chk("hz2_bubble_cnt", 32'(bubble_cnt), 32'd2);
    step();
    chk("hz2_reissue_src2", 32'(ex_src2), 32'd3);
    $display("txn load-use src2 bubble_cnt=%0d", bubble_cnt);
  endtask

  task automatic test_flush_stall();
    in_valid = 1'b1; instr = I_ADD_OK; step();
    chk("fl_pre_valid", 32'(ex_valid), 32'd1);
    flush = 1'b1; stall_in = 1'b1; #1;
    chk("fl_if_stall", 32'(if_stall), 32'd0);
    step();
    chk("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk("fl_ex_wb_en", 32'(ex_wb_en), 32'd0);
    flush = 1'b0; stall_in = 1'b0;
    // Flush of a load must not create a hazard on the next instruction.
    instr = I_LD; step();
    flush = 1'b1; instr = I_ADD_HZ; #1;
    chk("fl_ld_if_stall", 32'(if_stall), 32'd0);
    step();
    flush = 1'b0;
    chk("fl_ld_bubble_cnt", 32'(bubble_cnt), 32'd2);
    chk("fl_ld_ex_mem_r_en", 32'(ex_mem_r_en), 32'd0);
    $display("txn flush+stall ex_valid=%0d", ex_valid);
  endtask

  task automatic test_stall_hold();
    in_valid = 1'b1; instr = I_ADDI; rf_rdata1 = 32'd10; rf_rdata2 = 32'h1234; step();
    stall_in = 1'b1; instr = I_ST; rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_if_stall", 32'(if_stall), 32'd1);
      step();
      chk("stall_ex_valid", 32'(ex_valid), 32'd1);
      chk("stall_ex_val1", ex_val1, 32'd10);
      chk("stall_ex_val2", ex_val2, 32'hFFFFFFFC);
      chk("stall_ex_dest", 32'(ex_dest), 32'd2);
      chk("stall_ex_wb_en", 32'(ex_wb_en), 32'd1);
      $display("txn stall cycle %0d val1=0x%0h", c, ex_val1);
    end
    stall_in = 1'b0;
  endtask

  task automatic test_decode_misc();
    in_valid = 1'b1; instr = I_ST; rf_rdata1 = 32'h200; rf_rdata2 = 32'h77; step();
    chk("st_mem_w_en", 32'(ex_mem_w_en), 32'd1);
    chk("st_wb_en", 32'(ex_wb_en), 32'd0);
    chk("st_val2", ex_val2, 32'd8);
    chk("st_reg2", ex_reg2, 32'h77);
    chk("st_dest", 32'(ex_dest), 32'd2);
    instr = 32'h0C000000 | I_ADD_HZ[25:0]; rf_rdata1 = 32'd5; rf_rdata2 = 32'd3; step();
    chk("sub_exe_cmd", 32'(ex_exe_cmd), 32'd2);
    chk("sub_val2", ex_val2, 32'd3);
    instr = I_BNE; step();
    chk("bne_br_type", 32'(ex_br_type), 32'd2);
    chk("bne_val2", ex_val2, 32'hFFFFFFF0);
    instr = 32'h0; step();
    chk("nop_valid", 32'(ex_valid), 32'd0);
    instr = I_UNK; step();
    chk("unk_valid", 32'(ex_valid), 32'd0);
    chk("unk_wb_en", 32'(ex_wb_en), 32'd0);
    instr = I_ADDI; in_valid = 1'b0; step();
    chk("idle_valid", 32'(ex_valid), 32'd0);
    $display("txn decode misc done");
  endtask

  task automatic test_fwd();
    logic [31:0] exp_val1;
`ifdef ID_WB_FWD_EN
    exp_val1 = 32'h55;
`else
    exp_val1 = 32'h0;
`endif
    in_valid = 1'b1; instr = I_ADDI; rf_rdata1 = 32'd0;
    wb_we = 1'b1; wb_dest = 5'd1; wb_data = 32'h55; step();
    chk("fwd_ex_val1", ex_val1, exp_val1);
    wb_we = 1'b0; wb_dest = '0; wb_data = '0;
    $display("txn fwd val1=0x%0h", ex_val1);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; instr = I_ADDI; rf_rdata1 = 32'd10; step();
    chk("ar_pre_valid", 32'(ex_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_ex_valid", 32'(ex_valid), 32'd0);
    chk("ar_ex_val1", ex_val1, 32'd0);
    chk("ar_ex_dest", 32'(ex_dest), 32'd0);
    chk("ar_bubble_cnt", 32'(bubble_cnt), 32'd0);
    step();
    rst = 1'b1; in_valid = 1'b0;
    $display("txn async reset done");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_flush_stall();
    test_stall_hold();
    test_decode_misc();
    test_fwd();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage with the ID/EX pipeline register built in.
- Decodes one instruction per cycle and forms Val1/Val2/Dest/src fields and control bits, then registers them toward EXE.
- Adds behaviour the previous decode stage did not have: internal load-use hazard detection with bubble insertion, stall/flush priority, and a bubble counter.
- Sits between the IF/ID register and EXE; the register file sits outside the block.

Parameters:
- XLEN, 32, datapath width of register values and immediates after sign extension.
- RADDR_W, 5, register-address width; instruction fields are truncated to this width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instr is valid.
- instr  in  32  instruction word.
- rf_raddr1  out  RADDR_W  instr[25:21], combinational.
- rf_raddr2  out  RADDR_W  instr[20:16], combinational.
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data.
- stall_in  in  1  downstream stall; freezes ID/EX.
- flush  in  1  taken branch in EXE; kills ID and the ID/EX contents.
- wb_we, wb_dest, wb_data  in  1/RADDR_W/XLEN  writeback bypass (used only with ID_WB_FWD_EN).
- if_stall  out  1  hold PC and IF/ID; combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_src1, ex_src2, ex_dest  out  RADDR_W  registered.
- ex_val1, ex_val2, ex_reg2  out  XLEN  registered.
- ex_exe_cmd  out  4  registered.
- ex_br_type  out  2  registered.
- ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_one_input  out  1  registered.
- bubble_cnt  out  CNT_W  hazard bubbles inserted, saturating.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0 and bubble_cnt is 0. if_stall follows its equation with ex_valid=0, so it equals stall_in.
- Decode (combinational, in sub-module):
  - is_imm selects ex_val2 = sign-extended instr[15:0]; otherwise rdata2.
  - is_imm selects dest = instr[20:16]; otherwise instr[15:11].
  - src2 = 0 when is_imm; otherwise instr[20:16].
  - ex_reg2 always takes rdata2, so stores keep their data.
  - Unknown opcode decodes as NOP with all controls 0.
- Hazard: hz = in_valid & ex_valid & ex_mem_r_en & ex_dest!=0 & (ex_dest==src1 | (!one_input & ex_dest==src2)).
- Per-edge priority, highest first:
  - flush: ex_valid and all control bits go to 0; data fields don't-care. The current ID instruction is dropped. if_stall=0.
  - stall_in: ID/EX holds all fields. if_stall=1.
  - hz: bubble; ex_valid and controls go to 0. if_stall=1 for exactly one cycle. bubble_cnt increments, saturating at 2^CNT_W-1.
  - in_valid: load the decoded fields. ex_valid = 1, except ex_valid = 0 for NOP.
  - otherwise: load a bubble; bubble_cnt does not increment.
- if_stall = !flush & (stall_in | hz).
- Latency: 1 cycle from instr to ex_*.
- Flush and stall_in both high: flush wins.
- After a hazard bubble, the same instruction reissues the next cycle. hz is then 0 because ex_valid=0.

Optional Feature:
- Macro ID_WB_FWD_EN.
- Defined: if wb_we & wb_dest!=0 & wb_dest==rf_raddrN, the value loaded for that operand is wb_data instead of rf_rdataN. This applies to val1, and to val2/reg2 for operand 2.
- Undefined: the wb_* ports exist but are ignored; the register file must write-before-read.

Decomposition:
- Package id_pkg holds:
  - Opcodes: OP_NOP=0, OP_ADD=1, OP_SUB=3, OP_ADDI=32, OP_LD=36, OP_ST=37, OP_BEZ=40, OP_BNE=41, OP_JMP=42.
  - EXE_CMD codes: ADD=0, SUB=2.
  - BR_TYPE codes: NONE=0, BEZ=1, BNE=2, JMP=3.
  - A control-bundle typedef.
- Sub-module id_decoder: combinational; maps opcode to exe_cmd/br_type/mem_r/mem_w/wb_en/is_imm/one_input.
- The top level holds the ID/EX register, hazard logic and counter.

Test Plan:
- ADDI r2,r1,-4 (instr 0x8022FFFC), rf_rdata1=10 -> next cycle: ex_val1=10, ex_val2=0xFFFFFFFC, ex_dest=2, ex_src2=0, ex_wb_en=1, ex_valid=1.
- LD r3,0(r1) then ADD r4,r3,r5 -> if_stall=1 for one cycle, one bubble (ex_valid=0), ADD issues the following cycle, bubble_cnt=1; with ADD r4,r5,r0 instead, no stall.
- flush=1 and stall_in=1 in the same cycle with ADD valid -> ex_valid=0, if_stall=0.
- stall_in high for 3 cycles -> ex_* unchanged throughout, if_stall=1 throughout.
- rst pulled low mid-stream, asynchronously -> all ex_* and bubble_cnt are 0 before the next edge.
- With ID_WB_FWD_EN: wb_we=1, wb_dest=1, wb_data=0x55, rf_rdata1=0, src1=1 -> ex_val1=0x55. Without the macro -> ex_val1=0.
